// File: rtl/ws2812_rx_decoder_if.sv
// Bus bundle for ws2812_rx_decoder: serial line in, decoded word and status out.
// master = stimulus/driver side, slave = decoder side.
interface ws2812_rx_decoder_if;
    logic        din;
    logic [23:0] color_out;
    logic        color_valid;
    logic        frame_err;
    logic [4:0]  bit_count;
    logic        dout;

    modport master (
        output din,
        input  color_out, color_valid, frame_err, bit_count, dout
    );

    modport slave (
        input  din,
        output color_out, color_valid, frame_err, bit_count, dout
    );
endinterface

// File: rtl/ws2812_rx_decoder.sv
// WS2812 one-wire NRZ receiver: decodes 24-bit GRB words, latched on a reset gap.
// Optional pass-through of bits 25+ on dout when WS2812_RX_FWD_EN is defined.
module ws2812_rx_decoder #(
    parameter int unsigned BIT_THRESH   = 30,
    parameter int unsigned MIN_HIGH     = 8,
    parameter int unsigned MAX_HIGH     = 55,
    parameter int unsigned RESET_CYCLES = 2000,
    parameter int unsigned CNT_W        = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ws2812_rx_decoder_if.slave   bus
);

    typedef enum logic [1:0] {
        ARM,
        WAIT,
        HIGH
    } state_t;

    localparam logic [CNT_W-1:0] RESET_C  = CNT_W'(RESET_CYCLES);
    localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_HIGH);
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(BIT_THRESH);
    localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_HIGH);
    localparam logic [4:0]       FULL_C   = 5'd24;

    logic             sync1_q;
    logic             s_q;
    logic             s_prev_q;
    state_t           state_q,       state_d;
    logic [CNT_W-1:0] low_cnt_q,     low_cnt_d;
    logic [CNT_W-1:0] high_cnt_q,    high_cnt_d;
    logic [23:0]      shift_q,       shift_d;
    logic [4:0]       bit_count_q,   bit_count_d;
    logic [23:0]      color_q,       color_d;
    logic             color_valid_q, color_valid_d;
    logic             frame_err_q,   frame_err_d;

    logic             rise;
    logic [CNT_W-1:0] low_inc;
    logic [CNT_W-1:0] high_inc;
    logic             low_done;

    assign rise     = s_q & ~s_prev_q;
    // Low counter saturates at RESET_CYCLES so a long idle yields one end-of-frame event.
    assign low_inc  = (low_cnt_q == RESET_C) ? low_cnt_q : low_cnt_q + 1'b1;
    assign low_done = (low_cnt_q != RESET_C) && (low_inc == RESET_C);
    assign high_inc = high_cnt_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        low_cnt_d     = low_cnt_q;
        high_cnt_d    = high_cnt_q;
        shift_d       = shift_q;
        bit_count_d   = bit_count_q;
        color_d       = color_q;
        color_valid_d = 1'b0;
        frame_err_d   = 1'b0;

        case (state_q)
            ARM: begin
                if (s_q) begin
                    low_cnt_d = '0;
                end else begin
                    low_cnt_d = low_inc;
                    if (low_done) begin
                        state_d     = WAIT;
                        bit_count_d = '0;
                    end
                end
            end

            WAIT: begin
                if (rise) begin
                    high_cnt_d = '0;
                    low_cnt_d  = '0;
                    state_d    = HIGH;
                end else if (!s_q) begin
                    low_cnt_d = low_inc;
                    if (low_done && (bit_count_q != '0)) begin
                        if (bit_count_q == FULL_C) begin
                            color_d       = shift_q;
                            color_valid_d = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                        bit_count_d = '0;
                    end
                end
            end

            HIGH: begin
                if (!s_q) begin
                    // Pulses shorter than MIN_HIGH leave the captured word untouched.
                    state_d = WAIT;
                    if ((high_cnt_q >= MIN_C) && (bit_count_q < FULL_C)) begin
                        shift_d     = {shift_q[22:0], (high_cnt_q >= THRESH_C)};
                        bit_count_d = bit_count_q + 5'd1;
                    end
                end else begin
                    high_cnt_d = high_inc;
                    if (high_inc == MAX_C) begin
                        frame_err_d = 1'b1;
                        bit_count_d = '0;
                        low_cnt_d   = '0;
                        state_d     = ARM;
                    end
                end
            end

            default: state_d = ARM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q       <= 1'b0;
            s_q           <= 1'b0;
            s_prev_q      <= 1'b0;
            state_q       <= ARM;
            low_cnt_q     <= '0;
            high_cnt_q    <= '0;
            shift_q       <= '0;
            bit_count_q   <= '0;
            color_q       <= '0;
            color_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            sync1_q       <= bus.din;
            s_q           <= sync1_q;
            s_prev_q      <= s_q;
            state_q       <= state_d;
            low_cnt_q     <= low_cnt_d;
            high_cnt_q    <= high_cnt_d;
            shift_q       <= shift_d;
            bit_count_q   <= bit_count_d;
            color_q       <= color_d;
            color_valid_q <= color_valid_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign bus.color_out   = color_q;
    assign bus.color_valid = color_valid_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.bit_count   = bit_count_q;

`ifdef WS2812_RX_FWD_EN
    // Once 24 bits are held, the synchronised line is passed straight to the next pixel.
    assign bus.dout = s_q && (bit_count_q == FULL_C) && (state_q != ARM);
`else
    assign bus.dout = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812_rx_decoder.sv
// Scoreboard bench for ws2812_rx_decoder: expected latch/error events queued at stimulus time.
module tb_ws2812_rx_decoder;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    ws2812_rx_decoder_if bus();

    ws2812_rx_decoder #(
        .BIT_THRESH   (30),
        .MIN_HIGH     (8),
        .MAX_HIGH     (55),
        .RESET_CYCLES (2000),
        .CNT_W        (12)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic        is_err;
        logic [23:0] color;
    } ev_t;

    ev_t         exp_q[$];
    int          checks        = 0;
    int          errors        = 0;
    int          cyc           = 0;
    int          last_fall_cyc = 0;
    int          dout_hi_cnt   = 0;
    logic [23:0] model_color   = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.dout === 1'b1) dout_hi_cnt++;
            if (bus.color_valid || bus.frame_err) begin
                check_eq("valid_err_overlap", {31'b0, bus.color_valid & bus.frame_err}, 32'd0);
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_evt", {30'b0, bus.color_valid, bus.frame_err}, 32'd0);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    check_eq("evt_kind", {31'b0, bus.frame_err}, {31'b0, e.is_err});
                    check_eq("color_out", {8'b0, bus.color_out}, {8'b0, e.color});
                    if (!e.is_err)
                        check_eq("valid_latency", cyc - last_fall_cyc, 32'd2003);
                end
            end
        end
    end

    task automatic send_bit(input logic b);
        bus.din = 1'b1;
        repeat (b ? 41 : 21) @(negedge clk);
        bus.din = 1'b0;
        last_fall_cyc = cyc;
        repeat (b ? 22 : 42) @(negedge clk);
    endtask

    task automatic send_word(input logic [23:0] w);
        for (int i = 23; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic idle(input int n);
        bus.din = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic push_valid(input logic [23:0] w);
        exp_q.push_back({1'b0, w});
        model_color = w;
    endtask

    task automatic push_err();
        exp_q.push_back({1'b1, model_color});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        logic [23:0] w;
        int exp_dout;

        bus.din = 1'b0;
        rst_n   = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_color_out",   {8'b0, bus.color_out}, 32'd0);
        check_eq("rst_color_valid", {31'b0, bus.color_valid}, 32'd0);
        check_eq("rst_frame_err",   {31'b0, bus.frame_err}, 32'd0);
        check_eq("rst_bit_count",   {27'b0, bus.bit_count}, 32'd0);
        check_eq("rst_dout",        {31'b0, bus.dout}, 32'd0);
        rst_n = 1'b1;

        // basic frame after arming
        idle(2000);
        send_word(24'h00FF00);
        push_valid(24'h00FF00);
        idle(2500);
        check_eq("drain_basic", exp_q.size(), 32'd0);

        // driver-style repeated frames
        for (int k = 0; k < 2; k++) begin
            send_word(24'h123456);
            push_valid(24'h123456);
            idle(2100);
            check_eq("drain_driver", exp_q.size(), 32'd0);
        end

        // short frame
        w = 24'h2AA5C3;
        for (int i = 0; i < 10; i++) send_bit(w[23-i]);
        repeat (5) @(negedge clk);
        check_eq("short_bit_count", {27'b0, bus.bit_count}, 32'd10);
        push_err();
        idle(2100);
        check_eq("drain_short", exp_q.size(), 32'd0);
        check_eq("short_bc_clear", {27'b0, bus.bit_count}, 32'd0);
        check_eq("short_color_held", {8'b0, bus.color_out}, 32'h123456);

        // glitch between bits 5 and 6
        w = 24'hA5A5A5;
        for (int i = 23; i >= 0; i--) begin
            send_bit(w[i]);
            if (i == 18) begin
                bus.din = 1'b1;
                repeat (4) @(negedge clk);
                bus.din = 1'b0;
                repeat (20) @(negedge clk);
            end
        end
        push_valid(24'hA5A5A5);
        idle(2100);
        check_eq("drain_glitch", exp_q.size(), 32'd0);

        // over-long high, then frame with insufficient idle is ignored
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        push_err();
        bus.din = 1'b1;
        repeat (60) @(negedge clk);
        idle(500);
        check_eq("maxhigh_bc", {27'b0, bus.bit_count}, 32'd0);
        send_word(24'h0F0F0F);
        idle(500);
        check_eq("ignored_bc", {27'b0, bus.bit_count}, 32'd0);
        idle(1600);
        send_word(24'h5A3C0F);
        push_valid(24'h5A3C0F);
        idle(2100);
        check_eq("drain_rearm", exp_q.size(), 32'd0);

        // 48-bit frame: saturation and forwarding
        d0 = dout_hi_cnt;
        send_word(24'h111111);
        check_eq("dout_first24", dout_hi_cnt - d0, 32'd0);
        send_word(24'h222222);
        check_eq("sat_bit_count", {27'b0, bus.bit_count}, 32'd24);
        push_valid(24'h111111);
        idle(2100);
        check_eq("drain_48", exp_q.size(), 32'd0);
`ifdef WS2812_RX_FWD_EN
        exp_dout = 6 * 41 + 18 * 21;
`else
        exp_dout = 0;
`endif
        check_eq("dout_cycles", dout_hi_cnt - d0, exp_dout);
        check_eq("dout_idle", {31'b0, bus.dout}, 32'd0);

        // asynchronous reset mid-frame
        for (int i = 0; i < 12; i++) send_bit(i[0]);
        rst_n   = 1'b0;
        bus.din = 1'b0;
        @(negedge clk);
        check_eq("midrst_color", {8'b0, bus.color_out}, 32'd0);
        check_eq("midrst_bc",    {27'b0, bus.bit_count}, 32'd0);
        rst_n = 1'b1;
        model_color = '0;
        idle(2100);
        send_word(24'hC0FFEE);
        push_valid(24'hC0FFEE);
        idle(2100);
        check_eq("drain_postrst", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
